// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit-framer state encoding.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned PRE_LEN = 8;
    localparam int unsigned FCS_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAD,
        FCS,
        DRAIN,
        IFG
    } tx_state_e;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Byte stream handshake from the MAC packet buffer into the GMII transmit framer.
interface gmii_tx_framer_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 next-state function (reflected, LSB first); purely combinational.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional pad + FCS (GMII_TX_FCS_EN), IFG,
// plus the RGMII rise/fall nibble pairs taken straight from the registered GMII outputs.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned IFG_BYTES   = 12,
    parameter int unsigned MIN_PAYLOAD = 60
) (
    input  logic             gmii_tx_clk,
    input  logic             sys_rst,
    gmii_tx_framer_if.slave  s,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic [7:0]       gmii_tx_data,
    output logic [3:0]       rgmii_txd_rise,
    output logic [3:0]       rgmii_txd_fall,
    output logic             rgmii_ctl_rise,
    output logic             rgmii_ctl_fall,
    output logic             underrun
);

    tx_state_e   state_q;
    logic [7:0]  aux_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic [7:0]  tx_data_q;
    logic        s_ready_q;
    logic        underrun_q;
    logic        hs;

    assign hs = s.s_valid & s_ready_q;

`ifdef GMII_TX_FCS_EN
    logic [15:0] byte_cnt_q;
    logic [15:0] byte_cnt_inc;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [7:0]  crc_byte;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
    assign crc_byte     = (state_q == PAD) ? 8'h00 : s.s_data;
    assign fcs_word     = ~crc_q;
    // aux_q counts 0..3 through FCS; transmit least-significant byte first
    assign fcs_byte     = fcs_word[{aux_q[1:0], 3'b000} +: 8];

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_d)
    );
`endif

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            aux_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            tx_data_q  <= '0;
            s_ready_q  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef GMII_TX_FCS_EN
            byte_cnt_q <= '0;
            crc_q      <= CRC32_INIT;
`endif
        end else begin
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s.s_valid) begin
                        state_q   <= PRE;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= PREAMBLE_BYTE;
                        aux_q     <= 8'd1;
`ifdef GMII_TX_FCS_EN
                        byte_cnt_q <= '0;
                        crc_q      <= CRC32_INIT;
`endif
                    end
                end
                PRE: begin
                    tx_en_q <= 1'b1;
                    if (aux_q == 8'(PRE_LEN - 1)) begin
                        // open the input while SFD is on the wire so payload follows with no bubble
                        tx_data_q <= SFD_BYTE;
                        s_ready_q <= 1'b1;
                        aux_q     <= '0;
                        state_q   <= DATA;
                    end else begin
                        tx_data_q <= PREAMBLE_BYTE;
                        aux_q     <= aux_q + 8'd1;
                    end
                end
                DATA: begin
                    tx_en_q <= 1'b1;
                    if (hs) begin
                        tx_data_q <= s.s_data;
`ifdef GMII_TX_FCS_EN
                        byte_cnt_q <= byte_cnt_inc;
                        crc_q      <= crc_d;
`endif
                        if (s.s_last) begin
                            s_ready_q <= 1'b0;
`ifdef GMII_TX_FCS_EN
                            state_q   <= (byte_cnt_inc < 16'(MIN_PAYLOAD)) ? PAD : FCS;
`else
                            state_q   <= IFG;
`endif
                        end
                    end else begin
                        tx_er_q    <= 1'b1;
                        underrun_q <= 1'b1;
                        state_q    <= DRAIN;
                    end
                end
`ifdef GMII_TX_FCS_EN
                PAD: begin
                    tx_en_q    <= 1'b1;
                    byte_cnt_q <= byte_cnt_inc;
                    crc_q      <= crc_d;
                    if (byte_cnt_inc >= 16'(MIN_PAYLOAD)) begin
                        state_q <= FCS;
                    end
                end
                FCS: begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= fcs_byte;
                    if (aux_q == 8'(FCS_LEN - 1)) begin
                        aux_q   <= '0;
                        state_q <= IFG;
                    end else begin
                        aux_q <= aux_q + 8'd1;
                    end
                end
`endif
                DRAIN: begin
                    if (hs && s.s_last) begin
                        s_ready_q <= 1'b0;
                        state_q   <= IFG;
                    end
                end
                IFG: begin
                    if (aux_q == 8'(IFG_BYTES - 1)) begin
                        aux_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        aux_q <= aux_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    s_ready_q <= 1'b0;
                    aux_q     <= '0;
                end
            endcase
        end
    end

    assign s.s_ready      = s_ready_q;
    assign gmii_tx_en     = tx_en_q;
    assign gmii_tx_er     = tx_er_q;
    assign gmii_tx_data   = tx_data_q;
    assign underrun       = underrun_q;
    assign rgmii_txd_rise = tx_data_q[3:0];
    assign rgmii_txd_fall = tx_data_q[7:4];
    assign rgmii_ctl_rise = tx_en_q;
    assign rgmii_ctl_fall = tx_en_q ^ tx_er_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomized bench for gmii_tx_framer against a queue-based frame model; also exercises crc32_d8 alone.
module tb_gmii_tx_framer;

    localparam int IFG  = 12;
    localparam int MINP = 60;
`ifdef GMII_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tx_en, tx_er, und, ctl_r, ctl_f;
    logic [7:0] tx_d;
    logic [3:0] txd_r, txd_f;

    gmii_tx_framer_if sif ();

    gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
        .gmii_tx_clk    (clk),
        .sys_rst        (rst),
        .s              (sif),
        .gmii_tx_en     (tx_en),
        .gmii_tx_er     (tx_er),
        .gmii_tx_data   (tx_d),
        .rgmii_txd_rise (txd_r),
        .rgmii_txd_fall (txd_f),
        .rgmii_ctl_rise (ctl_r),
        .rgmii_ctl_fall (ctl_f),
        .underrun       (und)
    );

    logic [31:0] c_in, c_out;
    logic [7:0]  c_dat;
    crc32_d8 u_crc_alone (.crc_in(c_in), .data(c_dat), .crc_out(c_out));

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int gap = IFG;
    int last_len = 0;
    int last_gap = 0;
    int frames_done = 0;
    int under_pulses = 0;
    bit in_frame = 1'b0;
    bit b2b_ok = 1'b0;

    logic [7:0]  pay[$];
    logic [8:0]  exp_bytes[$];
    int          exp_len[$];
    int          exp_gap[$];
    logic [31:0] crc_tab[256];

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        return (c >> 8) ^ crc_tab[c[7:0] ^ b];
    endfunction

    // Expected wire image of one frame: {tx_er, byte} per tx_en cycle.
    task automatic model_frame(input int k, input int g);
        logic [31:0] c;
        int n;
        exp_gap.push_back(g);
        for (int j = 0; j < 7; j++) exp_bytes.push_back(9'h055);
        exp_bytes.push_back(9'h0D5);
        n = 8;
        if (k >= 0) begin
            for (int j = 0; j < k; j++) exp_bytes.push_back({1'b0, pay[j]});
            exp_bytes.push_back(9'h100);
            n += k + 1;
        end else begin
            c = 32'hFFFFFFFF;
            foreach (pay[j]) begin
                exp_bytes.push_back({1'b0, pay[j]});
                c = crc_step(c, pay[j]);
                n++;
            end
            if (FCS_ON) begin
                for (int j = pay.size(); j < MINP; j++) begin
                    exp_bytes.push_back(9'h000);
                    c = crc_step(c, 8'h00);
                    n++;
                end
                for (int j = 0; j < 4; j++) begin
                    exp_bytes.push_back({1'b0, 8'((~c) >> (8 * j))});
                    n++;
                end
            end
        end
        exp_len.push_back(n);
    endtask

    task automatic mon_loop();
        logic [8:0] cur_exp[$];
        logic [8:0] bad_act, bad_exp;
        int L, g, pos, bad_at;
        bit bad;
        L = 0; pos = 0; bad = 1'b0; bad_at = 0; bad_act = '0; bad_exp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                gap = IFG;
                continue;
            end
            chk(txd_r == tx_d[3:0] && txd_f == tx_d[7:4], "rgmii_txd", 32'({txd_f, txd_r}), 32'(tx_d));
            chk(ctl_r == tx_en && ctl_f == (tx_en ^ tx_er), "rgmii_ctl", 32'({ctl_r, ctl_f}),
                32'({tx_en, tx_en ^ tx_er}));
            chk(und == tx_er, "underrun_vs_er", 32'(und), 32'(tx_er));
            if (tx_er) under_pulses++;
            if (tx_en) begin
                if (!in_frame) begin
                    in_frame = 1'b1; pos = 0; bad = 1'b0;
                    cur_exp.delete();
                    if (exp_len.size() == 0) begin
                        chk(1'b0, "unexpected_frame", 32'd1, 32'd0);
                        L = 0;
                    end else begin
                        L = exp_len.pop_front();
                        g = exp_gap.pop_front();
                        for (int j = 0; j < L; j++) cur_exp.push_back(exp_bytes.pop_front());
                        last_gap = gap;
                        if (g > 0) chk(gap == g, "gap_exact", gap, g);
                        else       chk(gap >= IFG, "gap_min", gap, IFG);
                    end
                end
                if (pos < L && !bad && {tx_er, tx_d} != cur_exp[pos]) begin
                    bad = 1'b1; bad_at = pos; bad_act = {tx_er, tx_d}; bad_exp = cur_exp[pos];
                end
                pos++;
            end else begin
                chk(!tx_er && tx_d == 8'h00, "idle_symbol", 32'({tx_er, tx_d}), 32'd0);
                if (in_frame) begin
                    in_frame = 1'b0;
                    chk(pos == L, "frame_len", pos, L);
                    chk(!bad, $sformatf("frame_byte[%0d]", bad_at), 32'(bad_act), 32'(bad_exp));
                    last_len = pos;
                    frames_done++;
                    gap = 1;
                end else begin
                    gap++;
                end
            end
        end
    endtask

    task automatic send(input int k, input int pre_idle, input int rst_at);
        int i, t, g;
        bit hs, dropped;
        repeat (pre_idle) begin @(posedge clk); #1; end
        g = (pre_idle == 0 && b2b_ok) ? IFG : 0;
        model_frame(k, g);
        i = 0; dropped = 1'b0;
        while (i < pay.size()) begin
            if (k >= 0 && i == k && !dropped) begin
                sif.s_valid = 1'b0; sif.s_last = 1'b0; dropped = 1'b1;
                @(posedge clk); #1;
                continue;
            end
            sif.s_valid = 1'b1;
            sif.s_data  = pay[i];
            sif.s_last  = (i == pay.size() - 1);
            if (i == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk(tx_en == 1'b0, "rst_tx_en", 32'(tx_en), 32'd0);
                chk(sif.s_ready == 1'b0, "rst_s_ready", 32'(sif.s_ready), 32'd0);
                rst = 1'b0;
                break;
            end
            hs = 1'b0; t = 0;
            while (!hs && t < 1000) begin
                @(negedge clk); hs = sif.s_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!hs) begin
                chk(1'b0, "handshake_timeout", 32'(i), 32'(pay.size()));
                break;
            end
            i++;
        end
        sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = 8'h00;
        b2b_ok = (k < 0 && rst_at < 0);
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 5000) begin @(posedge clk); #1; t++; end
        chk(frames_done >= target, "frame_wait_timeout", frames_done, target);
        b2b_ok = 1'b0;
    endtask

    task automatic fill_inc(input int n);
        pay.delete();
        for (int j = 0; j < n; j++) pay.push_back(8'(j + 1));
    endtask

    initial begin
        logic [31:0] c;
        logic [7:0]  msg[9];
        int n0, up0, len, k;

        rst = 1'b1;
        sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = 8'h00;
        c_in = '0; c_dat = '0;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end

        // crc32_d8 alone and the bench table model on the standard check string
        for (int j = 0; j < 9; j++) msg[j] = 8'h31 + 8'(j);
        c = 32'hFFFFFFFF;
        for (int j = 0; j < 9; j++) begin c_in = c; c_dat = msg[j]; #1; c = c_out; end
        chk(~c == 32'hCBF43926, "crc32_d8_check", ~c, 32'hCBF43926);
        begin
            logic [31:0] f;
            f = ~c;
            for (int j = 0; j < 4; j++) begin c_in = c; c_dat = 8'(f >> (8 * j)); #1; c = c_out; end
        end
        chk(c == 32'hDEBB20E3, "crc32_d8_residue", c, 32'hDEBB20E3);
        c = 32'hFFFFFFFF;
        for (int j = 0; j < 9; j++) c = crc_step(c, msg[j]);
        chk(~c == 32'hCBF43926, "model_crc_check", ~c, 32'hCBF43926);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(tx_en == 1'b0 && tx_er == 1'b0, "reset_en_er", 32'({tx_en, tx_er}), 32'd0);
        chk(tx_d == 8'h00, "reset_data", 32'(tx_d), 32'd0);
        chk(sif.s_ready == 1'b0, "reset_s_ready", 32'(sif.s_ready), 32'd0);
        chk(und == 1'b0 && ctl_f == 1'b0 && ctl_r == 1'b0, "reset_misc", 32'({und, ctl_f, ctl_r}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fork mon_loop(); join_none

        // short frames
        n0 = frames_done; fill_inc(10); send(-1, 2, -1); wait_frames(n0 + 1);
        chk(last_len == (FCS_ON ? 72 : 18), "short10_len", last_len, FCS_ON ? 72 : 18);
        n0 = frames_done; fill_inc(9); send(-1, 0, -1); wait_frames(n0 + 1);
        chk(last_len == (FCS_ON ? 72 : 17), "short9_len", last_len, FCS_ON ? 72 : 17);

        // back-to-back 64-byte frames
        n0 = frames_done;
        fill_inc(64); send(-1, 0, -1);
        for (int j = 0; j < 64; j++) pay[j] = 8'(8'hA0 ^ j);
        send(-1, 0, -1);
        wait_frames(n0 + 2);
        chk(last_gap == 12, "b2b_gap", last_gap, 12);
        chk(last_len == (FCS_ON ? 76 : 72), "b2b_len", last_len, FCS_ON ? 76 : 72);

        // underrun after 20 of 100
        n0 = frames_done; up0 = under_pulses;
        fill_inc(100); send(20, 0, -1); wait_frames(n0 + 1);
        chk(last_len == 29, "underrun_len", last_len, 29);
        chk(under_pulses - up0 == 1, "underrun_pulses", under_pulses - up0, 1);

        // mid-frame reset on payload byte 30, then a clean 60-byte frame
        fill_inc(60); send(-1, 3, 29);
        n0 = frames_done;
        for (int j = 0; j < 60; j++) pay[j] = 8'(8'hFF - j);
        send(-1, 4, -1); wait_frames(n0 + 1);
        chk(last_len == (FCS_ON ? 72 : 68), "post_reset_len", last_len, FCS_ON ? 72 : 68);

        // randomized traffic
        for (int f = 0; f < 30; f++) begin
            len = int'($urandom_range(80, 1));
            pay.delete();
            for (int j = 0; j < len; j++) pay.push_back(8'($urandom));
            k = (len >= 2 && $urandom_range(4, 0) == 0) ? int'($urandom_range(len - 1, 1)) : -1;
            send(k, ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(5, 1)), -1);
        end

        begin
            int t;
            t = 0;
            while ((exp_len.size() != 0 || in_frame) && t < 5000) begin @(posedge clk); #1; t++; end
            chk(exp_len.size() == 0 && !in_frame, "frames_pending", 32'(exp_len.size()), 32'd0);
        end
        repeat (IFG + 2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
